// File: rtl/fifo_ptr_sched.sv
// fifo_ptr_sched: pointer, occupancy and request scheduler for a FIFO whose
// storage is two single-port RAM banks selected by address LSB. The memory
// controller defers a write by one cycle on a same-bank read/write collision;
// this block mirrors that deferred write so it never targets a busy bank.
module fifo_ptr_sched #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_req,
  input  logic [31:0]      wr_data,
  output logic             wr_ack,
  input  logic             rd_req,
  output logic             rd_ack,
  output logic             rd_data_valid,
  output logic             rd_bank,
  output logic             WE_N,
  output logic             RE_N,
  output logic [WIDTH-1:0] W_ADR,
  output logic [WIDTH-1:0] R_ADR,
  output logic [31:0]      DI,
  output logic [WIDTH:0]   count,
  output logic             full,
  output logic             empty,
  output logic             pend,
  output logic             pend_bank
);

  localparam int DEPTH = 1 << WIDTH;

  logic [WIDTH-1:0] wr_ptr_reg;
  logic [WIDTH-1:0] rd_ptr_reg;
  logic [WIDTH:0]   count_reg;
  logic [WIDTH:0]   count_next;
  logic             pend_reg;
  logic             pend_bank_reg;
  logic             rd_data_valid_reg;
  logic             rd_bank_reg;

  logic             wr_bank;
  logic             rd_bank_now;
  logic             full_int;
  logic             empty_int;
  logic             wr_ok;
  logic             rd_ok;
  logic             collision;
  logic [1:0]       bank_blocked;

  // A bank is off-limits while the controller still holds a deferred write for it.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_bank
      assign bank_blocked[gi] = pend_reg & (pend_bank_reg == 1'(gi));
    end
  endgenerate

  assign wr_bank     = wr_ptr_reg[0];
  assign rd_bank_now = rd_ptr_reg[0];

  // Status comes from the registered count, i.e. start-of-cycle occupancy,
  // so a simultaneous pop never frees room for a push (and vice versa).
  assign full_int  = (count_reg == (WIDTH+1)'(DEPTH));
  assign empty_int = (count_reg == '0);

  // rst_n gates the acks so no strobe reaches the controller during reset.
  assign wr_ok = rst_n & wr_req & ~full_int  & ~bank_blocked[wr_bank];
  assign rd_ok = rst_n & rd_req & ~empty_int & ~bank_blocked[rd_bank_now];

  // Same-bank pair: the controller serves the read and parks the write.
  assign collision = wr_ok & rd_ok & (wr_bank == rd_bank_now);

  assign wr_ack        = wr_ok;
  assign rd_ack        = rd_ok;
  assign WE_N          = wr_ok;
  assign RE_N          = rd_ok;
  assign W_ADR         = wr_ptr_reg;
  assign R_ADR         = rd_ptr_reg;
  assign DI            = wr_data;
  assign count         = count_reg;
  assign full          = full_int;
  assign empty         = empty_int;
  assign pend          = pend_reg;
  assign pend_bank     = pend_bank_reg;
  assign rd_data_valid = rd_data_valid_reg;
  assign rd_bank       = rd_bank_reg;

  // Occupancy moves only when exactly one side is accepted.
  always_comb begin
    count_next = count_reg;
    case ({wr_ok, rd_ok})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  // Pointer, occupancy, deferred-write mirror and read-data tracking state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg        <= '0;
      rd_ptr_reg        <= '0;
      count_reg         <= '0;
      pend_reg          <= 1'b0;
      pend_bank_reg     <= 1'b0;
      rd_data_valid_reg <= 1'b0;
      rd_bank_reg       <= 1'b0;
    end else begin
      if (wr_ok) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (rd_ok) begin
        rd_ptr_reg  <= rd_ptr_reg + 1'b1;
        rd_bank_reg <= rd_bank_now;
      end
      count_reg         <= count_next;
      pend_reg          <= collision;
      if (collision) begin
        pend_bank_reg <= wr_bank;
      end
      rd_data_valid_reg <= rd_ok;
    end
  end

endmodule

// File: tb/tb_fifo_ptr_sched.sv
// Self-checking bench for fifo_ptr_sched: a transaction-count model is compared
// against every DUT output on each falling edge, with directed scenarios
// followed by randomized push/pop traffic and occasional resets.
module tb_fifo_ptr_sched;

  localparam int WIDTH = 4;
  localparam int DEPTH = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             wr_req;
  logic [31:0]      wr_data;
  logic             wr_ack;
  logic             rd_req;
  logic             rd_ack;
  logic             rd_data_valid;
  logic             rd_bank;
  logic             WE_N;
  logic             RE_N;
  logic [WIDTH-1:0] W_ADR;
  logic [WIDTH-1:0] R_ADR;
  logic [31:0]      DI;
  logic [WIDTH:0]   count;
  logic             full;
  logic             empty;
  logic             pend;
  logic             pend_bank;

  fifo_ptr_sched #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_req(wr_req), .wr_data(wr_data), .wr_ack(wr_ack),
    .rd_req(rd_req), .rd_ack(rd_ack),
    .rd_data_valid(rd_data_valid), .rd_bank(rd_bank),
    .WE_N(WE_N), .RE_N(RE_N), .W_ADR(W_ADR), .R_ADR(R_ADR), .DI(DI),
    .count(count), .full(full), .empty(empty),
    .pend(pend), .pend_bank(pend_bank)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;

  // Model: total accepted pushes/pops since reset; a deferred write is
  // remembered as the bank it occupies (-1 when none).
  bit     m_valid      = 1'b0;
  longint m_wr_total   = 0;
  longint m_rd_total   = 0;
  int     m_defer_bank = -1;
  bit     m_rdv        = 1'b0;
  int     m_rdb        = 0;

  function automatic longint m_count();
    return m_wr_total - m_rd_total;
  endfunction

  function automatic bit m_wr_ok();
    int b;
    b = int'(m_wr_total % 2);
    return rst_n && wr_req && (m_count() < DEPTH) && (m_defer_bank != b);
  endfunction

  function automatic bit m_rd_ok();
    int b;
    b = int'(m_rd_total % 2);
    return rst_n && rd_req && (m_count() > 0) && (m_defer_bank != b);
  endfunction

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
  endtask

  // Model update at the active edge, from the inputs the DUT also sampled.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) begin
      m_valid      <= 1'b1;
      m_wr_total   <= 0;
      m_rd_total   <= 0;
      m_defer_bank <= -1;
      m_rdv        <= 1'b0;
      m_rdb        <= 0;
    end else if (m_valid) begin
      m_wr_total   <= m_wr_total + longint'(m_wr_ok());
      m_rd_total   <= m_rd_total + longint'(m_rd_ok());
      m_defer_bank <= (m_wr_ok() && m_rd_ok() && (m_wr_total % 2 == m_rd_total % 2))
                      ? int'(m_wr_total % 2) : -1;
      m_rdv        <= m_rd_ok();
      if (m_rd_ok()) m_rdb <= int'(m_rd_total % 2);
    end
  end

  // Compare every output against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("wr_ack", 40'(wr_ack), 40'(m_wr_ok()));
      chk("rd_ack", 40'(rd_ack), 40'(m_rd_ok()));
      chk("WE_N", 40'(WE_N), 40'(m_wr_ok()));
      chk("RE_N", 40'(RE_N), 40'(m_rd_ok()));
      chk("W_ADR", 40'(W_ADR), 40'(m_wr_total % DEPTH));
      chk("R_ADR", 40'(R_ADR), 40'(m_rd_total % DEPTH));
      chk("DI", 40'(DI), 40'(wr_data));
      chk("count", 40'(count), 40'(m_count()));
      chk("full", 40'(full), 40'(m_count() == DEPTH));
      chk("empty", 40'(empty), 40'(m_count() == 0));
      chk("pend", 40'(pend), 40'(m_defer_bank >= 0));
      if (m_defer_bank >= 0) chk("pend_bank", 40'(pend_bank), 40'(m_defer_bank));
      chk("rd_data_valid", 40'(rd_data_valid), 40'(m_rdv));
      if (m_rdv) chk("rd_bank", 40'(rd_bank), 40'(m_rdb));
    end
  end

  // One cycle: drive inputs just after the edge, return at the falling edge.
  task automatic step(input bit w, input bit r, input logic [31:0] d, input bit rs_n);
    @(posedge clk);
    #1;
    rst_n   = rs_n;
    wr_req  = w;
    rd_req  = r;
    wr_data = d;
    @(negedge clk);
    $display("cyc=%0d rst_n=%0b wr_req=%0b rd_req=%0b wr_ack=%0b rd_ack=%0b W_ADR=%0d R_ADR=%0d count=%0d pend=%0b",
             cyc, rst_n, wr_req, rd_req, wr_ack, rd_ack, W_ADR, R_ADR, count, pend);
  endtask

  initial begin
    rst_n = 1'b0; wr_req = 1'b0; rd_req = 1'b0; wr_data = '0;
    step(0, 0, 0, 0);
    step(1, 1, 0, 0);
    chk("rst_no_we", 40'(WE_N), 40'(0));
    chk("rst_no_re", 40'(RE_N), 40'(0));
    step(0, 0, 0, 1);
    chk("rst_count", 40'(count), 40'(0));
    chk("rst_empty", 40'(empty), 40'(1));
    chk("rst_full", 40'(full), 40'(0));

    // Fill: sixteen pushes, then a refused seventeenth.
    for (int i = 0; i < DEPTH; i++) begin
      step(1, 0, 32'h1000 + 32'(i), 1);
      chk("fill_ack", 40'(wr_ack), 40'(1));
      chk("fill_adr", 40'(W_ADR), 40'(i));
    end
    step(1, 0, 32'h1010, 1);
    chk("fill_count", 40'(count), 40'(16));
    chk("fill_full", 40'(full), 40'(1));
    chk("fill_17th_ack", 40'(wr_ack), 40'(0));
    chk("model_full", 40'(m_count()), 40'(16));

    // Drain: sixteen pops with alternating read banks.
    for (int i = 0; i < DEPTH; i++) begin
      step(0, 1, 0, 1);
      chk("drain_ack", 40'(rd_ack), 40'(1));
      chk("drain_adr", 40'(R_ADR), 40'(i));
      if (i > 0) chk("drain_bank", 40'(rd_bank), 40'((i - 1) % 2));
    end
    step(0, 0, 0, 1);
    chk("drain_empty", 40'(empty), 40'(1));
    chk("drain_last_bank", 40'(rd_bank), 40'(1));

    // Collision stream: rd_ptr=0, wr_ptr=2, then four push+pop cycles.
    step(1, 0, 32'hA0, 1);
    step(1, 0, 32'hA1, 1);
    for (int k = 0; k < 5; k++) begin
      step(k < 4, k < 4, 32'hB0 + 32'(k), 1);
      if (k < 4) begin
        chk("coll_wr_ack", 40'(wr_ack), 40'(1));
        chk("coll_rd_ack", 40'(rd_ack), 40'(1));
      end
      if (k >= 1) begin
        chk("coll_pend", 40'(pend), 40'(1));
        chk("coll_pend_bank", 40'(pend_bank), 40'((k - 1) % 2));
        chk("coll_count", 40'(count), 40'(2));
      end
    end

    // Boundary at full: pop accepted, push refused.
    for (int i = 0; i < 14; i++) step(1, 0, 32'hC0 + 32'(i), 1);
    step(0, 0, 0, 1);
    chk("bnd_full", 40'(full), 40'(1));
    step(1, 1, 32'hCF, 1);
    chk("bnd_full_rd", 40'(rd_ack), 40'(1));
    chk("bnd_full_wr", 40'(wr_ack), 40'(0));
    step(0, 0, 0, 1);
    chk("bnd_full_count", 40'(count), 40'(15));

    // Boundary at empty: push accepted, pop refused.
    for (int i = 0; i < 15; i++) step(0, 1, 0, 1);
    step(0, 0, 0, 1);
    chk("bnd_empty", 40'(empty), 40'(1));
    step(1, 1, 32'hD0, 1);
    chk("bnd_empty_wr", 40'(wr_ack), 40'(1));
    chk("bnd_empty_rd", 40'(rd_ack), 40'(0));
    step(0, 0, 0, 1);
    chk("bnd_empty_count", 40'(count), 40'(1));

    // Reset with a deferred write outstanding.
    step(0, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(1, 0, 32'hE0 + 32'(i), 1);
    step(1, 1, 32'hE8, 1);
    step(1, 1, 32'hE9, 0);
    chk("mid_pend_before", 40'(pend), 40'(1));
    chk("mid_count_before", 40'(count), 40'(8));
    chk("mid_no_we", 40'(WE_N), 40'(0));
    chk("mid_no_re", 40'(RE_N), 40'(0));
    chk("mid_no_wr_ack", 40'(wr_ack), 40'(0));
    chk("mid_no_rd_ack", 40'(rd_ack), 40'(0));
    step(0, 0, 0, 1);
    chk("mid_count_after", 40'(count), 40'(0));
    chk("mid_pend_after", 40'(pend), 40'(0));
    chk("mid_rdv_after", 40'(rd_data_valid), 40'(0));

    // Randomized traffic with shifting push/pop bias and rare resets.
    for (int seg = 0; seg < 12; seg++) begin
      int pw;
      int pr;
      pw = int'($urandom_range(10, 95));
      pr = int'($urandom_range(10, 95));
      for (int i = 0; i < 250; i++) begin
        step(($urandom_range(0, 99) < pw), ($urandom_range(0, 99) < pr),
             $urandom, ($urandom_range(0, 299) != 0));
      end
    end
    step(0, 0, 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
